dmem_access_controller: RTL and testbench

DMEM_ACCESS_CONTROLLER -- requirements
Module: dmem_access_controller

---
 rtl/dmem_access_controller_pkg.sv | 59 +++++
 rtl/dmem_access_controller_load_data_extender.sv | 35 +++
 rtl/dmem_access_controller.sv | 128 ++++++++++++
 tb/tb_dmem_access_controller.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_controller_pkg.sv
// -----------------------------------------------------------------------------
// dmem_access_controller_pkg
// Shared definitions for the data-memory access path: FUNCT3 access codes,
// access FSM state encoding, and small helpers for alignment checking and
// store lane formatting.
// -----------------------------------------------------------------------------
package dmem_access_controller_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    // Undefined FUNCT3 codes report as not aligned so they take the
    // misaligned path and never reach memory.
    function automatic logic access_aligned(input logic [2:0] funct3,
                                            input logic [1:0] offset);
        logic ok;
        case (funct3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = ~offset[0];
            F3_LW:         ok = (offset == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_byte_en(input logic [2:0] funct3,
                                                 input logic [1:0] offset);
        logic [3:0] be;
        case (funct3)
            F3_LB, F3_LBU: be = 4'b0001 << offset;
            F3_LH, F3_LHU: be = 4'b0011 << offset;
            default:       be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data is replicated into every lane so the byte enables alone
    // decide which bytes land in memory.
    function automatic logic [31:0] store_lane_data(input logic [2:0]  funct3,
                                                    input logic [31:0] data);
        logic [31:0] lanes;
        case (funct3)
            F3_LB, F3_LBU: lanes = {4{data[7:0]}};
            F3_LH, F3_LHU: lanes = {2{data[15:0]}};
            default:       lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/dmem_access_controller_load_data_extender.sv
// -----------------------------------------------------------------------------
// load_data_extender
// Combinational lane select and sign/zero extension of a loaded memory word.
// Ports:
//   funct3      - access size/sign code captured with the request
//   byte_offset - byte address bits [1:0] captured with the request
//   mem_word    - raw 32-bit word returned by memory
//   load_value  - extended result for the register file
// -----------------------------------------------------------------------------
module load_data_extender
    import dmem_access_controller_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_offset,
    input  logic [31:0] mem_word,
    output logic [31:0] load_value
);

    logic [31:0] shifted;

    // Word accesses are always at offset 0, so the shift is a no-op for them.
    assign shifted = mem_word >> {byte_offset, 3'b000};

    always_comb begin
        load_value = shifted;
        case (funct3)
            F3_LB:   load_value = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_value = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_value = {24'h000000, shifted[7:0]};
            F3_LHU:  load_value = {16'h0000, shifted[15:0]};
            default: load_value = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_access_controller.sv
// -----------------------------------------------------------------------------
// dmem_access_controller
// Stage-4 data memory access controller. Accepts load/store requests from the
// pipeline, checks alignment, runs a handshake with the data memory, and
// returns the extended load result.
//
// state  | meaning
// IDLE   | waiting for a request; aligned request stalls and launches access
// ACCESS | strobe held on memory until DMEM_ACK
// DONE   | one cycle with BUSYWAIT low so the pipeline advances
//
// Ports:
//   CLK, RESET            - clock, async active-low reset
//   MEM_READ, MEM_WRITE   - pipeline load/store request (both high = store)
//   FUNCT3, ADDRESS       - access size/sign and byte address
//   WRITE_DATA            - store data
//   READ_DATA             - extended load result, held until next load
//   BUSYWAIT              - pipeline stall request
//   MISALIGNED            - one-cycle flag for rejected requests
//   DMEM_READ/DMEM_WRITE  - memory strobes
//   DMEM_ADDR             - word address
//   DMEM_WRITEDATA        - lane-replicated store data
//   DMEM_BYTE_EN          - store byte enables (zero when not writing)
//   DMEM_READDATA         - memory word
//   DMEM_ACK              - one-cycle memory completion
// -----------------------------------------------------------------------------
module dmem_access_controller
    import dmem_access_controller_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MISALIGNED,
    output logic        DMEM_READ,
    output logic        DMEM_WRITE,
    output logic [29:0] DMEM_ADDR,
    output logic [31:0] DMEM_WRITEDATA,
    output logic [3:0]  DMEM_BYTE_EN,
    input  logic [31:0] DMEM_READDATA,
    input  logic        DMEM_ACK
);

    state_t      state;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic        request;
    logic        aligned;
    logic        start;
    logic [31:0] load_value;

    assign request = MEM_READ | MEM_WRITE;
    assign aligned = access_aligned(FUNCT3, ADDRESS[1:0]);
    assign start   = (state == ST_IDLE) && request && aligned;

    // The stall must be visible in the request cycle itself, so it is the one
    // combinational output.
    assign BUSYWAIT = start || (state == ST_ACCESS);

    load_data_extender u_extender (
        .funct3      (funct3_q),
        .byte_offset (offset_q),
        .mem_word    (DMEM_READDATA),
        .load_value  (load_value)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state          <= ST_IDLE;
            funct3_q       <= 3'b000;
            offset_q       <= 2'b00;
            READ_DATA      <= 32'h0;
            MISALIGNED     <= 1'b0;
            DMEM_READ      <= 1'b0;
            DMEM_WRITE     <= 1'b0;
            DMEM_ADDR      <= 30'h0;
            DMEM_WRITEDATA <= 32'h0;
            DMEM_BYTE_EN   <= 4'b0000;
        end else begin
            MISALIGNED <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (request) begin
                        if (aligned) begin
                            funct3_q       <= FUNCT3;
                            offset_q       <= ADDRESS[1:0];
                            DMEM_ADDR      <= ADDRESS[31:2];
                            DMEM_WRITEDATA <= store_lane_data(FUNCT3, WRITE_DATA);
                            if (MEM_WRITE) begin
                                DMEM_WRITE   <= 1'b1;
                                DMEM_BYTE_EN <= store_byte_en(FUNCT3, ADDRESS[1:0]);
                            end else begin
                                DMEM_READ    <= 1'b1;
                                DMEM_BYTE_EN <= 4'b0000;
                            end
                            state <= ST_ACCESS;
                        end else begin
                            MISALIGNED <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (DMEM_ACK) begin
                        DMEM_READ    <= 1'b0;
                        DMEM_WRITE   <= 1'b0;
                        DMEM_BYTE_EN <= 4'b0000;
                        if (DMEM_READ) begin
                            READ_DATA <= load_value;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_controller.sv
module tb_dmem_access_controller;

    logic        CLK;
    logic        RESET;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
    logic        MISALIGNED;
    logic        DMEM_READ;
    logic        DMEM_WRITE;
    logic [29:0] DMEM_ADDR;
    logic [31:0] DMEM_WRITEDATA;
    logic [3:0]  DMEM_BYTE_EN;
    logic [31:0] DMEM_READDATA;
    logic        DMEM_ACK;

    dmem_access_controller dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .MEM_READ       (MEM_READ),
        .MEM_WRITE      (MEM_WRITE),
        .FUNCT3         (FUNCT3),
        .ADDRESS        (ADDRESS),
        .WRITE_DATA     (WRITE_DATA),
        .READ_DATA      (READ_DATA),
        .BUSYWAIT       (BUSYWAIT),
        .MISALIGNED     (MISALIGNED),
        .DMEM_READ      (DMEM_READ),
        .DMEM_WRITE     (DMEM_WRITE),
        .DMEM_ADDR      (DMEM_ADDR),
        .DMEM_WRITEDATA (DMEM_WRITEDATA),
        .DMEM_BYTE_EN   (DMEM_BYTE_EN),
        .DMEM_READDATA  (DMEM_READDATA),
        .DMEM_ACK       (DMEM_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit        is_write;
        bit [29:0] waddr;
        bit [3:0]  be;
        bit [31:0] wdata;
        bit [31:0] rdata;
    } txn_t;

    txn_t        exp_q[$];
    int          checks;
    int          errors;
    int          mis_expected;
    int          mis_seen;
    int          ack_delay;
    bit [7:0]    ref_bytes[1024];
    logic [31:0] mem[256];

    // responder state
    bit          rsp_waiting;
    bit          rsp_ack_on;
    int          rsp_cnt;

    // monitor state
    txn_t        cur;
    bit          in_acc;
    bit          pend;
    logic [31:0] last_rd;
    logic [31:0] next_rd;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int size_of(input bit [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    // Reference model: byte-addressed memory, updated in request order.
    task automatic issue(input bit rd, input bit wr, input bit [2:0] f3,
                         input bit [31:0] addr, input bit [31:0] data, input int delay);
        int   size;
        bit   ok;
        txn_t t;
        int   bw;
        int   base;
        bit [31:0] v;
        size = size_of(f3);
        ok   = (size != 0) && ((int'(addr[1:0]) % size) == 0);
        @(negedge CLK);
        ack_delay  = delay;
        MEM_READ   = rd;
        MEM_WRITE  = wr;
        FUNCT3     = f3;
        ADDRESS    = addr;
        WRITE_DATA = data;
        if (!(rd || wr)) begin
            #1;
            check32("idle_busywait", 32'(BUSYWAIT), 32'd0);
            return;
        end
        base = int'(addr[9:0]);
        if (!ok) begin
            mis_expected++;
        end else begin
            t.is_write = wr;
            t.waddr    = addr[31:2];
            t.be       = 4'b0000;
            t.wdata    = 32'h0;
            t.rdata    = 32'h0;
            if (wr) begin
                for (int j = 0; j < size; j++) begin
                    t.be[int'(addr[1:0]) + j] = 1'b1;
                    ref_bytes[base + j] = data[8*j +: 8];
                end
                for (int i = 0; i < 4; i++) t.wdata[8*i +: 8] = data[8*(i % size) +: 8];
            end else begin
                v = 32'h0;
                for (int j = 0; j < size; j++) v = v | (32'(ref_bytes[base + j]) << (8*j));
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
                t.rdata = v;
            end
            exp_q.push_back(t);
        end
        bw = 0;
        for (int n = 0; n < 64; n++) begin
            #1;
            if (!BUSYWAIT) break;
            bw++;
            @(negedge CLK);
        end
        check32("busywait_cycles", 32'(bw), ok ? 32'(delay + 2) : 32'd0);
    endtask

    // Memory responder with configurable ACK delay and stray ACKs while idle.
    initial begin
        DMEM_ACK      = 1'b0;
        DMEM_READDATA = 32'h0;
        rsp_waiting   = 1'b0;
        rsp_ack_on    = 1'b0;
        rsp_cnt       = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (rsp_ack_on) begin
                DMEM_ACK      = 1'b0;
                rsp_ack_on    = 1'b0;
                DMEM_READDATA = $urandom;
            end
            if (!rsp_waiting && (DMEM_READ || DMEM_WRITE)) begin
                rsp_waiting = 1'b1;
                rsp_cnt     = ack_delay;
            end
            if (rsp_waiting) begin
                if (rsp_cnt == 0) begin
                    rsp_waiting = 1'b0;
                    if (DMEM_WRITE) begin
                        for (int i = 0; i < 4; i++)
                            if (DMEM_BYTE_EN[i]) mem[DMEM_ADDR[7:0]][8*i +: 8] = DMEM_WRITEDATA[8*i +: 8];
                    end
                    DMEM_READDATA = mem[DMEM_ADDR[7:0]];
                    DMEM_ACK      = 1'b1;
                    rsp_ack_on    = 1'b1;
                end else begin
                    rsp_cnt--;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                DMEM_ACK   = 1'b1;
                rsp_ack_on = 1'b1;
            end
        end
    end

    // Monitor: pops expected transactions when a memory access starts and
    // checks the captured load result in the cycle after the ACK.
    initial begin
        in_acc  = 1'b0;
        pend    = 1'b0;
        last_rd = 32'h0;
        next_rd = 32'h0;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                in_acc  = 1'b0;
                pend    = 1'b0;
                last_rd = 32'h0;
                continue;
            end
            if (!DMEM_WRITE) check32("byte_en_idle", 32'(DMEM_BYTE_EN), 32'd0);
            if (pend) begin
                check32("read_data_capture", READ_DATA, next_rd);
                check32("strobe_drop", {30'h0, DMEM_READ, DMEM_WRITE}, 32'd0);
                check32("done_busywait", 32'(BUSYWAIT), 32'd0);
                last_rd = next_rd;
                pend    = 1'b0;
            end else begin
                check32("read_data_hold", READ_DATA, last_rd);
            end
            if (MISALIGNED) mis_seen++;
            if ((DMEM_READ || DMEM_WRITE) && !in_acc) begin
                if (exp_q.size() == 0) begin
                    check32("unexpected_strobe", {30'h0, DMEM_READ, DMEM_WRITE}, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check32("strobe_dir", {30'h0, DMEM_READ, DMEM_WRITE},
                            cur.is_write ? 32'd1 : 32'd2);
                    check32("dmem_addr", 32'(DMEM_ADDR), 32'(cur.waddr));
                    check32("dmem_byte_en", 32'(DMEM_BYTE_EN), 32'(cur.be));
                    if (cur.is_write) check32("dmem_writedata", DMEM_WRITEDATA, cur.wdata);
                    in_acc = 1'b1;
                end
            end
            if (in_acc) begin
                check32("access_busywait", 32'(BUSYWAIT), 32'd1);
                if (DMEM_ACK) begin
                    pend    = 1'b1;
                    in_acc  = 1'b0;
                    next_rd = cur.is_write ? last_rd : cur.rdata;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        txn_t t;
        bit   rd;
        bit   wr;
        bit [31:0] a;
        checks       = 0;
        errors       = 0;
        mis_expected = 0;
        mis_seen     = 0;
        ack_delay    = 0;
        RESET        = 1'b0;
        MEM_READ     = 1'b0;
        MEM_WRITE    = 1'b0;
        FUNCT3       = 3'b000;
        ADDRESS      = 32'h0;
        WRITE_DATA   = 32'h0;
        for (int i = 0; i < 1024; i++) ref_bytes[i] = 8'($urandom);
        for (int w = 0; w < 256; w++)
            mem[w] = {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};

        #12;
        check32("rst_read_data", READ_DATA, 32'h0);
        check32("rst_strobes", {30'h0, DMEM_READ, DMEM_WRITE}, 32'd0);
        check32("rst_busywait", 32'(BUSYWAIT), 32'd0);
        check32("rst_misaligned", 32'(MISALIGNED), 32'd0);
        check32("rst_addr", 32'(DMEM_ADDR), 32'd0);
        check32("rst_wdata", DMEM_WRITEDATA, 32'h0);
        check32("rst_byte_en", 32'(DMEM_BYTE_EN), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;

        issue(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h8000_00F1, 2);
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 3);
        check32("lw_read_data", READ_DATA, 32'h8000_00F1);
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 1);
        check32("lb_sign_ext", READ_DATA, 32'hFFFF_FF80);
        issue(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 0);
        check32("lbu_zero_ext", READ_DATA, 32'h0000_0080);
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 1);
        check32("store_keeps_rd", READ_DATA, 32'h0000_0080);
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 0);
        issue(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0, 2);
        check32("lh_sign_ext", READ_DATA, 32'hFFFF_ABCD);
        issue(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 0);
        issue(1'b1, 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 1);
        issue(1'b1, 1'b0, 3'b101, 32'h0000_0106, 32'h0, 4);
        check32("lhu_zero_ext", READ_DATA, 32'h0000_DEAD);

        // reset in the middle of an access, memory ACK arrives afterwards
        @(negedge CLK);
        t.is_write = 1'b0;
        t.waddr    = 30'h40;
        t.be       = 4'b0000;
        t.wdata    = 32'h0;
        t.rdata    = 32'h0;
        exp_q.push_back(t);
        ack_delay = 6;
        MEM_READ  = 1'b1;
        MEM_WRITE = 1'b0;
        FUNCT3    = 3'b010;
        ADDRESS   = 32'h0000_0100;
        @(negedge CLK);
        MEM_READ = 1'b0;
        #2;
        RESET = 1'b0;
        #1;
        check32("midrst_strobes", {30'h0, DMEM_READ, DMEM_WRITE}, 32'd0);
        check32("midrst_busywait", 32'(BUSYWAIT), 32'd0);
        check32("midrst_read_data", READ_DATA, 32'h0);
        check32("midrst_addr", 32'(DMEM_ADDR), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (9) @(negedge CLK);
        #1;
        check32("stray_ack_no_capture", READ_DATA, 32'h0);
        check32("stray_ack_idle", 32'(BUSYWAIT), 32'd0);

        for (int n = 0; n < 400; n++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            issue(rd, wr, 3'($urandom_range(0, 7)), a, $urandom, $urandom_range(0, 4));
        end

        @(negedge CLK);
        MEM_READ  = 1'b0;
        MEM_WRITE = 1'b0;
        repeat (6) @(negedge CLK);
        check32("queue_drained", 32'(exp_q.size()), 32'd0);
        check32("misaligned_pulses", 32'(mis_seen), 32'(mis_expected));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
